// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, prefix-progress tracking,
// overlap control, a received-bit history and a saturating match counter.
module seq_detector_param #(
  parameter int                 PAT_LEN  = 7,
  parameter logic [PAT_LEN-1:0] PAT_INIT = 7'b1100111,
  parameter int                 HIST_W   = 10,
  parameter int                 OVERLAP  = 1,
  parameter int                 CNT_W    = 8,
  localparam int                PW       = $clog2(PAT_LEN + 1)
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_value,
  input  logic               cnt_clr,
  output logic               match,
  output logic               match_hold,
  output logic [PW-1:0]      progress,
  output logic [HIST_W-1:0]  history,
  output logic [CNT_W-1:0]   match_count
);

  logic [PAT_LEN-1:0] pat_reg;
  logic [PAT_LEN-1:0] win_reg;
  logic [PAT_LEN-1:0] win_next;
  logic [PW-1:0]      vcnt_reg;
  logic [PW-1:0]      vcnt_next;
  logic [PW-1:0]      prog_next;
  logic [PAT_LEN-1:0] hit;
  logic               accept;
  logic               is_match;
  logic               match_reg;
  logic               hold_reg;
  logic [PW-1:0]      progress_reg;
  logic [HIST_W-1:0]  history_reg;
  logic [CNT_W-1:0]   count_reg;

  // win_reg holds the last PAT_LEN accepted bits; vcnt_reg counts how many of
  // them arrived since the last restart, so stale bits never form a prefix.
  assign accept    = bit_valid & ~pat_load;
  assign win_next  = {win_reg[PAT_LEN-2:0], bit_in};
  assign vcnt_next = (vcnt_reg == PW'(PAT_LEN)) ? vcnt_reg : vcnt_reg + PW'(1);

  // hit[gi]: the newest gi+1 bits equal the first gi+1 pattern bits.
  generate
    for (genvar gi = 0; gi < PAT_LEN; gi++) begin : g_prefix
      localparam int                 K    = gi + 1;
      localparam logic [PAT_LEN-1:0] MASK = {PAT_LEN{1'b1}} >> (PAT_LEN - K);
      assign hit[gi] = (((win_next ^ (pat_reg >> (PAT_LEN - K))) & MASK) == '0)
                       && (vcnt_next >= PW'(K));
    end
  endgenerate

  always_comb begin
    prog_next = '0;
    for (int k = 0; k < PAT_LEN; k++) begin
      if (hit[k]) prog_next = PW'(k + 1);
    end
  end

  assign is_match = (prog_next == PW'(PAT_LEN));

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pat_reg      <= PAT_INIT;
      win_reg      <= '0;
      vcnt_reg     <= '0;
      progress_reg <= '0;
      history_reg  <= '0;
      match_reg    <= 1'b0;
      hold_reg     <= 1'b0;
      count_reg    <= '0;
    end else begin
      match_reg <= 1'b0;
      if (pat_load) begin
        pat_reg      <= pat_value;
        vcnt_reg     <= '0;
        progress_reg <= '0;
        hold_reg     <= 1'b0;
      end else if (bit_valid) begin
        win_reg      <= win_next;
        history_reg  <= {history_reg[HIST_W-2:0], bit_in};
        progress_reg <= prog_next;
        // Without overlap a completed match restarts detection from scratch.
        vcnt_reg     <= (is_match && (OVERLAP == 0)) ? '0 : vcnt_next;
        match_reg    <= is_match;
        hold_reg     <= is_match;
      end

      if (cnt_clr) begin
        count_reg <= (accept && is_match) ? CNT_W'(1) : '0;
      end else if (accept && is_match && (count_reg != '1)) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign match       = match_reg;
  assign match_hold  = hold_reg;
  assign progress    = progress_reg;
  assign history     = history_reg;
  assign match_count = count_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a vector table on the default instance plus
// hand sequences for overlap, saturation and mid-sequence reset corner cases.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic [6:0] pat_value = 7'd0;
  logic       cnt_clr = 1'b0;
  logic [1:0] pat_value_c = 2'b11;

  logic       m_a, h_a;
  logic [2:0] p_a;
  logic [9:0] hist_a;
  logic [7:0] cnt_a;
  logic       m_b, h_b;
  logic [2:0] p_b;
  logic [9:0] hist_b;
  logic [7:0] cnt_b;
  logic       m_c, h_c;
  logic [1:0] p_c;
  logic [9:0] hist_c;
  logic [1:0] cnt_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .CLOCK_50(clk), .RESET(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .pat_load(pat_load), .pat_value(pat_value), .cnt_clr(cnt_clr),
    .match(m_a), .match_hold(h_a), .progress(p_a), .history(hist_a), .match_count(cnt_a)
  );

  seq_detector_param #(.OVERLAP(0)) dut_no (
    .CLOCK_50(clk), .RESET(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .pat_load(pat_load), .pat_value(pat_value), .cnt_clr(cnt_clr),
    .match(m_b), .match_hold(h_b), .progress(p_b), .history(hist_b), .match_count(cnt_b)
  );

  seq_detector_param #(.PAT_LEN(2), .PAT_INIT(2'b11), .CNT_W(2)) dut_c (
    .CLOCK_50(clk), .RESET(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .pat_load(pat_load), .pat_value(pat_value_c), .cnt_clr(cnt_clr),
    .match(m_c), .match_hold(h_c), .progress(p_c), .history(hist_c), .match_count(cnt_c)
  );

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic       bin;
    logic       load;
    logic [6:0] pval;
    logic       clr;
    logic       m;
    logic       h;
    logic [2:0] p;
    logic [9:0] hist;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic v, logic b, logic l, logic [6:0] pv, logic c,
                              logic m, logic h, logic [2:0] p, logic [9:0] hs, logic [7:0] cn);
    vec_t t;
    t = '{rst: r, valid: v, bin: b, load: l, pval: pv, clr: c,
          m: m, h: h, p: p, hist: hs, cnt: cn};
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic b, input logic l, input logic c);
    rst = r;
    bit_valid = v;
    bit_in = b;
    pat_load = l;
    cnt_clr = c;
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b v=%0b b=%0b load=%0b clr=%0b | A m=%0b h=%0b p=%0d hist=%h cnt=%0d",
             $time, r, v, b, l, c, m_a, h_a, p_a, hist_a, cnt_a);
  endtask

  initial begin
    int na, nb, nc;
    logic [10:0] seq_a;
    logic [11:0] seq_b;
    logic [6:0]  seq_d;
    logic [1:0]  exp_c[4];

    // Defaults: bits 1100111 then overlap continuation, pattern load, new pattern.
    add(1, 0, 0, 0, 7'd0, 0,  0, 0, 0, 10'h000, 0);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 1, 10'h001, 0);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 2, 10'h003, 0);
    add(0, 1, 0, 0, 7'd0, 0,  0, 0, 3, 10'h006, 0);
    add(0, 1, 0, 0, 7'd0, 0,  0, 0, 4, 10'h00C, 0);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 5, 10'h019, 0);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 6, 10'h033, 0);
    add(0, 1, 1, 0, 7'd0, 0,  1, 1, 7, 10'h067, 1);
    add(0, 0, 0, 0, 7'd0, 0,  0, 1, 7, 10'h067, 1);
    add(0, 0, 0, 0, 7'd0, 1,  0, 1, 7, 10'h067, 0);
    add(0, 1, 0, 0, 7'd0, 0,  0, 0, 3, 10'h0CE, 0);
    add(0, 1, 0, 0, 7'd0, 0,  0, 0, 4, 10'h19C, 0);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 5, 10'h339, 0);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 6, 10'h273, 0);
    add(0, 1, 1, 0, 7'd0, 0,  1, 1, 7, 10'h0E7, 1);
    add(0, 1, 1, 1, 7'b1010101, 0,  0, 0, 0, 10'h0E7, 1);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 1, 10'h1CF, 1);
    add(0, 1, 0, 0, 7'd0, 0,  0, 0, 2, 10'h39E, 1);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 3, 10'h33D, 1);
    add(0, 1, 0, 0, 7'd0, 0,  0, 0, 4, 10'h27A, 1);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 5, 10'h0F5, 1);
    add(0, 1, 0, 0, 7'd0, 0,  0, 0, 6, 10'h1EA, 1);
    add(0, 1, 1, 0, 7'd0, 0,  1, 1, 7, 10'h3D5, 2);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 1, 10'h3AB, 2);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 1, 10'h357, 2);
    add(0, 1, 0, 0, 7'd0, 0,  0, 0, 2, 10'h2AE, 2);
    add(0, 1, 0, 0, 7'd0, 0,  0, 0, 0, 10'h15C, 2);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 1, 10'h2B9, 2);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 1, 10'h173, 2);
    add(0, 1, 1, 0, 7'd0, 0,  0, 0, 1, 10'h2E7, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      pat_value = vecs[i].pval;
      drive(vecs[i].rst, vecs[i].valid, vecs[i].bin, vecs[i].load, vecs[i].clr);
      chk($sformatf("vec%0d.match", i), 32'(m_a), 32'(vecs[i].m));
      chk($sformatf("vec%0d.hold", i), 32'(h_a), 32'(vecs[i].h));
      chk($sformatf("vec%0d.progress", i), 32'(p_a), 32'(vecs[i].p));
      chk($sformatf("vec%0d.history", i), 32'(hist_a), 32'(vecs[i].hist));
      chk($sformatf("vec%0d.count", i), 32'(cnt_a), 32'(vecs[i].cnt));
    end
    pat_value = 7'd0;

    // Failure-function fallback: 6 -> 3, then a single match on the 11th bit.
    drive(1, 0, 0, 0, 0);
    seq_a = 11'b11001100111;
    na = 0;
    nb = 0;
    for (int i = 10; i >= 0; i--) begin
      drive(0, 1, seq_a[i], 0, 0);
      if (m_a) na++;
      if (m_b) nb++;
      if (i == 5) chk("fallback.prog6", 32'(p_a), 32'd6);
      if (i == 4) chk("fallback.prog3", 32'(p_a), 32'd3);
    end
    chk("fallback.last_match", 32'(m_a), 32'd1);
    chk("fallback.matches", 32'(na), 32'd1);
    chk("fallback.matches_nooverlap", 32'(nb), 32'd1);

    // Overlap vs restart on 1100111 00111.
    drive(1, 0, 0, 0, 0);
    seq_b = 12'b110011100111;
    na = 0;
    nb = 0;
    for (int i = 11; i >= 0; i--) begin
      drive(0, 1, seq_b[i], 0, 0);
      if (m_a) na++;
      if (m_b) nb++;
    end
    chk("overlap.matches", 32'(na), 32'd2);
    chk("overlap.count", 32'(cnt_a), 32'd2);
    chk("nooverlap.matches", 32'(nb), 32'd1);
    chk("nooverlap.count", 32'(cnt_b), 32'd1);

    // Saturation on the 2-bit counter instance, then clear coinciding with a match.
    drive(1, 0, 0, 0, 0);
    exp_c[0] = 2'd1;
    exp_c[1] = 2'd2;
    exp_c[2] = 2'd3;
    exp_c[3] = 2'd3;
    drive(0, 1, 1, 0, 0);
    chk("sat.first_bit_count", 32'(cnt_c), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 0, 0);
      chk($sformatf("sat.match%0d", i), 32'(m_c), 32'd1);
      chk($sformatf("sat.count%0d", i), 32'(cnt_c), 32'(exp_c[i]));
    end
    drive(0, 1, 1, 0, 1);
    chk("sat.clr_with_match", 32'(cnt_c), 32'd1);

    // Reset at progress 5 discards the partial match.
    drive(1, 0, 0, 0, 0);
    seq_d = 7'b1100111;
    for (int i = 6; i >= 2; i--) drive(0, 1, seq_d[i], 0, 0);
    chk("rst.prog5", 32'(p_a), 32'd5);
    drive(1, 1, 1, 0, 0);
    chk("rst.progress", 32'(p_a), 32'd0);
    chk("rst.history", 32'(hist_a), 32'd0);
    chk("rst.match", 32'(m_a), 32'd0);
    chk("rst.hold", 32'(h_a), 32'd0);
    chk("rst.count", 32'(cnt_a), 32'd0);
    nc = 0;
    for (int i = 6; i >= 0; i--) begin
      drive(0, 1, seq_d[i], 0, 0);
      if (m_a) nc++;
    end
    chk("rst.after_matches", 32'(nc), 32'd1);
    chk("rst.after_count", 32'(cnt_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
